fifo_push_arbiter: RTL

Round-robin arbiter that shares a single FIFO push port among NUM_REQ requesters using per-requester req/ack handshakes. It keeps an internal credit counter mirroring free FIFO slots, so a push is never issued into a full FIFO despite the registered push path. It sits between client request logic and the shared FIFO and exports occupancy and error status for the control/status registers.

---
 rtl/fifo_arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 30 +++
 rtl/fifo_push_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared defaults for the FIFO push arbiter and its round-robin picker.
package fifo_arb_pkg;

  localparam int unsigned NUM_REQ_DEF  = 4;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned DEPTH_DEF    = 8;
  localparam int unsigned CNT_W_DEF    = 16;
  localparam int unsigned CREDIT_W_DEF = $clog2(DEPTH_DEF + 1);

  typedef logic [CREDIT_W_DEF-1:0] credit_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index at or after i_ptr, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_elig,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      logic [IDX_W-1:0] pos;
      pos = IDX_W'((32'(i_ptr) + k) % NUM_REQ);
      if (!o_valid && i_elig[pos]) begin
        o_valid      = 1'b1;
        o_idx        = pos;
        o_grant[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin sharing of one FIFO push port, with a credit counter that mirrors free
// FIFO slots so a registered push can never land in a full FIFO.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  localparam int unsigned CW     = $clog2(DEPTH + 1),
  localparam int unsigned IW     = $clog2(NUM_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_ack,
  output logic                      o_fifo_push,
  output logic [DATA_W-1:0]         o_fifo_wdata,
  input  logic                      i_fifo_pop,
  output logic [CW-1:0]             o_credits,
  output logic [IW-1:0]             o_grant_id,
  output logic [CNT_W-1:0]          o_push_cnt,
  output logic                      o_err
);

  logic [NUM_REQ-1:0] r_ack;
  logic [NUM_REQ-1:0] r_pending;
  logic               r_push;
  logic [DATA_W-1:0]  r_wdata;
  logic [CW-1:0]      r_credits;
  logic [IW-1:0]      r_grant_id;
  logic [IW-1:0]      r_rr_ptr;
  logic [CNT_W-1:0]   r_push_cnt;
  logic               r_err;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_onehot;
  logic [IW-1:0]      w_idx;
  logic               w_valid;
  logic               w_grant;
  logic [IW-1:0]      w_ptr_next;
  logic [DATA_W-1:0]  w_win_data;

  // The just-acked client still shows its stale req for one cycle; mask it out.
  assign w_elig = i_req & ~r_pending;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .i_elig (w_elig),
    .i_ptr  (r_rr_ptr),
    .o_grant(w_onehot),
    .o_idx  (w_idx),
    .o_valid(w_valid)
  );

  assign w_grant    = i_en && w_valid && (r_credits != '0);
  assign w_ptr_next = (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + IW'(1);
  assign w_win_data = i_req_data[w_idx*DATA_W +: DATA_W];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ack      <= '0;
      r_pending  <= '0;
      r_push     <= 1'b0;
      r_wdata    <= '0;
      r_credits  <= CW'(DEPTH);
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_push_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_push    <= w_grant;
      r_ack     <= w_grant ? w_onehot : '0;
      r_pending <= w_grant ? w_onehot : '0;
      if (w_grant) begin
        r_wdata    <= w_win_data;
        r_grant_id <= w_idx;
        r_rr_ptr   <= w_ptr_next;
        r_push_cnt <= r_push_cnt + CNT_W'(1);
      end
      // A grant and a pop together cancel out.
      if (w_grant && !i_fifo_pop) begin
        r_credits <= r_credits - CW'(1);
      end else if (!w_grant && i_fifo_pop) begin
        if (r_credits == CW'(DEPTH)) begin
          r_err <= 1'b1;
        end else begin
          r_credits <= r_credits + CW'(1);
        end
      end
    end
  end

  assign o_ack        = r_ack;
  assign o_fifo_push  = r_push;
  assign o_fifo_wdata = r_wdata;
  assign o_credits    = r_credits;
  assign o_grant_id   = r_grant_id;
  assign o_push_cnt   = r_push_cnt;
  assign o_err        = r_err;

endmodule
